// File: rtl/mac3_seq_pkg.sv
// rtl/mac3_seq_pkg.sv - shared state encoding and MAC latency constants for mac3_sequencer
package mac3_seq_pkg;

    // Fixed pipeline depth of the 3-lane MAC, from input_valid to mac_out.
    localparam int MAC_LATENCY = 4;

    // Enabled zero-operand cycles needed after the last issue to push the
    // final tag from tag[0] to tag[MAC_LATENCY-1].
    localparam int FLUSH_LEN = MAC_LATENCY - 1;

    localparam int FLUSH_CNT_WIDTH = $clog2(MAC_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac3_seq_tag_pipe.sv
// rtl/mac3_seq_tag_pipe.sv - enable-gated tag shift register tracking finished outputs through the MAC
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           advance the pipe (same cycle as MAC input_valid)
//   tag_in       1 when the issued group is the last of an output
//   clear_last   drop the last-stage tag once it has been captured
//   tag_last     last stage: mac_out holds a finished output this cycle
//   any_tag      at least one tag still in flight
module mac3_seq_tag_pipe
    import mac3_seq_pkg::*;
#(
    parameter int DEPTH = MAC_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tag_in,
    input  logic clear_last,
    output logic tag_last,
    output logic any_tag
);

    logic [DEPTH-1:0] tags;

    // When the pipe is frozen but the last tag was consumed, clear it so the
    // same mac_out is not captured twice. When the pipe advances, the shift
    // already retires the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
        end else if (en) begin
            tags <= {tags[DEPTH-2:0], tag_in};
        end else if (clear_last) begin
            tags[DEPTH-1] <= 1'b0;
        end
    end

    assign tag_last = tags[DEPTH-1];
    assign any_tag  = |tags;

endmodule

// File: rtl/mac3_sequencer.sv
// rtl/mac3_sequencer.sv - issue/result sequencer for one 3-lane pipelined MAC
//
// Ports:
//   clk, arst_n_in              clock, asynchronous active-low reset
//   start, num_groups,
//   num_outputs, use_bias       job launch and job shape (latched on start)
//   bias_in                     seed used on the first group of each output
//   op_valid/op_ready,
//   op_a, op_b                  operand triple stream {x2,x1,x0}
//   mac_input_valid,
//   mac_accumulate_internal,
//   mac_partial_sum,
//   mac_a, mac_b                MAC issue side
//   mac_out                     MAC result (already scaled/truncated)
//   mac_out_written_to_mem      pulse on each result handshake
//   res_valid/res_ready,
//   res_data                    captured result stream
//   busy, done                  job active / 1-cycle end-of-job pulse
module mac3_sequencer
    import mac3_seq_pkg::*;
#(
    parameter int A_WIDTH           = 16,
    parameter int B_WIDTH           = 16,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         arst_n_in,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         num_groups,
    input  logic [CNT_WIDTH-1:0]         num_outputs,
    input  logic                         use_bias,
    input  logic [ACCUMULATOR_WIDTH-1:0] bias_in,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [3*A_WIDTH-1:0]         op_a,
    input  logic [3*B_WIDTH-1:0]         op_b,
    output logic                         mac_input_valid,
    output logic                         mac_accumulate_internal,
    output logic [ACCUMULATOR_WIDTH-1:0] mac_partial_sum,
    output logic [3*A_WIDTH-1:0]         mac_a,
    output logic [3*B_WIDTH-1:0]         mac_b,
    output logic                         mac_out_written_to_mem,
    input  logic [OUTPUT_WIDTH-1:0]      mac_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [OUTPUT_WIDTH-1:0]      res_data,
    output logic                         busy,
    output logic                         done
);

    state_t                     state;
    state_t                     state_next;
    logic [CNT_WIDTH-1:0]       ng_q;
    logic [CNT_WIDTH-1:0]       no_q;
    logic                       use_bias_q;
    logic [CNT_WIDTH-1:0]       grp_cnt;
    logic [CNT_WIDTH-1:0]       out_cnt;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt;

    logic issue;
    logic last_grp;
    logic last_out;
    logic tag_last;
    logic any_tag;
    logic stall;
    logic capture;

    assign last_grp = (grp_cnt == ng_q - 1'b1);
    assign last_out = (out_cnt == no_q - 1'b1);

    // A finished output sitting at mac_out that cannot be captured freezes
    // the whole MAC so mac_out keeps presenting it.
    assign stall   = tag_last & res_valid & ~res_ready;
    assign capture = tag_last & ~stall;

    always_comb begin
        state_next              = state;
        op_ready                = 1'b0;
        issue                   = 1'b0;
        mac_input_valid         = 1'b0;
        mac_accumulate_internal = 1'b0;
        mac_partial_sum         = '0;
        mac_a                   = '0;
        mac_b                   = '0;
        done                    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_groups == '0 || num_outputs == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = COMPUTE;
                    end
                end
            end

            COMPUTE: begin
                op_ready        = ~stall;
                issue           = op_valid & ~stall;
                mac_input_valid = issue;
                mac_a           = op_a;
                mac_b           = op_b;
                if (grp_cnt == '0) begin
                    mac_accumulate_internal = 1'b0;
                    mac_partial_sum         = use_bias_q ? bias_in : '0;
                end else begin
                    mac_accumulate_internal = 1'b1;
                end
                if (issue && last_grp && last_out) begin
                    state_next = FLUSH;
                end
            end

            // Zero operands with accumulate=1 leave the accumulator untouched
            // while the last products drain through the pipe.
            FLUSH: begin
                mac_input_valid         = ~stall;
                mac_accumulate_internal = 1'b1;
                if (!stall && flush_cnt == FLUSH_CNT_WIDTH'(FLUSH_LEN - 1)) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (!res_valid && !any_tag) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state      <= IDLE;
            ng_q       <= '0;
            no_q       <= '0;
            use_bias_q <= 1'b0;
            grp_cnt    <= '0;
            out_cnt    <= '0;
            flush_cnt  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        ng_q       <= num_groups;
                        no_q       <= num_outputs;
                        use_bias_q <= use_bias;
                        grp_cnt    <= '0;
                        out_cnt    <= '0;
                        flush_cnt  <= '0;
                    end
                end
                COMPUTE: begin
                    if (issue) begin
                        if (last_grp) begin
                            grp_cnt <= '0;
                            out_cnt <= out_cnt + 1'b1;
                        end else begin
                            grp_cnt <= grp_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One-entry result buffer; accept and capture in the same cycle hand
    // over to the new data without a bubble.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= mac_out;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    mac3_seq_tag_pipe #(
        .DEPTH(MAC_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (arst_n_in),
        .en        (mac_input_valid),
        .tag_in    (issue & last_grp),
        .clear_last(capture),
        .tag_last  (tag_last),
        .any_tag   (any_tag)
    );

    assign mac_out_written_to_mem = res_valid & res_ready;
    assign busy                   = (state != IDLE);

endmodule

// File: tb/tb_mac3_sequencer.sv
// tb/tb_mac3_sequencer.sv - self-checking scoreboard bench for mac3_sequencer with a behavioural MAC
module tb_mac3_sequencer;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start;
    logic [15:0] num_groups;
    logic [15:0] num_outputs;
    logic        use_bias;
    logic [31:0] bias_in;
    logic        op_valid;
    logic        op_ready;
    logic [47:0] op_a;
    logic [47:0] op_b;
    logic        mac_input_valid;
    logic        mac_accumulate_internal;
    logic [31:0] mac_partial_sum;
    logic [47:0] mac_a;
    logic [47:0] mac_b;
    logic        mac_out_written_to_mem;
    logic [15:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    mac3_sequencer dut (
        .clk                    (clk),
        .arst_n_in              (arst_n_in),
        .start                  (start),
        .num_groups             (num_groups),
        .num_outputs            (num_outputs),
        .use_bias               (use_bias),
        .bias_in                (bias_in),
        .op_valid               (op_valid),
        .op_ready               (op_ready),
        .op_a                   (op_a),
        .op_b                   (op_b),
        .mac_input_valid        (mac_input_valid),
        .mac_accumulate_internal(mac_accumulate_internal),
        .mac_partial_sum        (mac_partial_sum),
        .mac_a                  (mac_a),
        .mac_b                  (mac_b),
        .mac_out_written_to_mem (mac_out_written_to_mem),
        .mac_out                (mac_out),
        .res_valid              (res_valid),
        .res_ready              (res_ready),
        .res_data               (res_data),
        .busy                   (busy),
        .done                   (done)
    );

    // Behavioural 4-stage MAC, OUTPUT_SCALE=0: products, register, accumulate, output.
    logic signed [31:0] prod_sum;
    logic signed [31:0] s1_sum, s2_sum, acc_r;
    logic               s1_ai, s2_ai;
    logic signed [31:0] s1_ps, s2_ps;

    always_comb begin
        prod_sum = 32'sd0;
        for (int l = 0; l < 3; l++) begin
            prod_sum = prod_sum + $signed(mac_a[16*l +: 16]) * $signed(mac_b[16*l +: 16]);
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            s1_sum <= '0; s2_sum <= '0; acc_r <= '0;
            s1_ai <= 1'b0; s2_ai <= 1'b0; s1_ps <= '0; s2_ps <= '0;
            mac_out <= '0;
        end else if (mac_input_valid) begin
            s1_sum  <= prod_sum;
            s1_ai   <= mac_accumulate_internal;
            s1_ps   <= $signed(mac_partial_sum);
            s2_sum  <= s1_sum;
            s2_ai   <= s1_ai;
            s2_ps   <= s1_ps;
            acc_r   <= (s2_ai ? acc_r : s2_ps) + s2_sum;
            mac_out <= acc_r[15:0];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    logic [15:0] exp_q[$];
    int          hs_cyc[$];
    int          done_cnt     = 0;
    int          miv_cnt      = 0;
    int          stall_seen   = 0;
    int          rise_cyc     = -1;
    int          last_acc_cyc = 0;
    int          rr_mode      = 0;

    always @(negedge clk) begin
        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(1));
            default: res_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every result handshake.
    logic        prev_hold = 1'b0;
    logic        prev_rv   = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        #2;
        if (arst_n_in) begin
            if (done) done_cnt++;
            if (mac_input_valid) miv_cnt++;
            if (res_valid && !prev_rv) rise_cyc = cyc;
            if (prev_hold) begin
                check("res_hold_valid", 64'(res_valid), 64'd1);
                check("res_hold_data", 64'(res_data), 64'(prev_data));
            end
            if (res_valid) begin
                check("written_to_mem", 64'(mac_out_written_to_mem), 64'(res_ready));
            end
            if (res_valid && res_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(res_data), 64'hDEAD_0000);
                end else begin
                    check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
                end
            end
            if (res_valid && !res_ready && op_valid && !op_ready) stall_seen++;
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_rv   = res_valid;
        end else begin
            prev_hold = 1'b0;
            prev_rv   = 1'b0;
        end
    end

    // mode 0 random, 1 a=1 b=2, 2 a=b=output+1, 3 deterministic index pattern
    task automatic run_job(input int ng, input int no, input bit ub, input logic [31:0] bias,
                           input int mode, input int bubble_pct, input bit check_lat, input bit abort);
        logic [47:0] qa[$];
        logic [47:0] qb[$];
        logic [47:0] a, b;
        int          acc;
        int          idx;
        int          waited;
        int          d0;
        int          m0;

        for (int o = 0; o < no; o++) begin
            acc = ub ? int'(bias) : 0;
            for (int g = 0; g < ng; g++) begin
                case (mode)
                    1:       begin a = {3{16'd1}}; b = {3{16'd2}}; end
                    2:       begin a = {3{16'(o + 1)}}; b = {3{16'(o + 1)}}; end
                    3:       begin a = {16'(qa.size() + 3), 16'(qa.size() + 1), 16'(-7)};
                                   b = {16'(9 - qa.size()), 16'(-2), 16'(qa.size() * 5)}; end
                    default: begin a = 48'({$urandom(), $urandom()}); b = 48'({$urandom(), $urandom()}); end
                endcase
                qa.push_back(a);
                qb.push_back(b);
                for (int l = 0; l < 3; l++) begin
                    acc += int'($signed(a[16*l +: 16])) * int'($signed(b[16*l +: 16]));
                end
            end
            if (!abort) exp_q.push_back(16'(acc));
        end

        d0       = done_cnt;
        m0       = miv_cnt;
        rise_cyc = -1;
        hs_cyc.delete();

        @(negedge clk);
        num_groups  = 16'(ng);
        num_outputs = 16'(no);
        use_bias    = ub;
        bias_in     = bias;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;

        if (qa.size() == 0) begin
            #3;
            check("zero_done_next", 64'(done), 64'd1);
        end else begin
            #1;
            check("busy_after_start", 64'(busy), 64'd1);
        end

        idx    = 0;
        waited = 0;
        while (idx < qa.size()) begin
            if (waited > 0) @(negedge clk);
            if (int'($urandom_range(99)) < bubble_pct) begin
                op_valid = 1'b0;
                op_a     = 48'({$urandom(), $urandom()});
                op_b     = '0;
            end else begin
                op_valid = 1'b1;
                op_a     = qa[idx];
                op_b     = qb[idx];
            end
            #1;
            if (op_valid && op_ready) begin
                check("acc_internal", 64'(mac_accumulate_internal), 64'((idx % ng) != 0));
                if ((idx % ng) == 0) begin
                    check("partial_sum", 64'(mac_partial_sum), ub ? 64'(bias) : 64'd0);
                end
                last_acc_cyc = cyc;
                idx++;
            end else if (!op_valid) begin
                check("bubble_no_mac", 64'(mac_input_valid), 64'd0);
            end
            waited++;
            if (waited > 5000) begin
                check("issue_timeout", 64'(idx), 64'(qa.size()));
                break;
            end
        end
        @(negedge clk);
        op_valid = 1'b0;

        if (abort) begin
            @(negedge clk);
            arst_n_in = 1'b0;
            #1;
            check("abort_res_valid", 64'(res_valid), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_done", 64'(done), 64'd0);
            check("abort_miv", 64'(mac_input_valid), 64'd0);
            check("abort_acc_int", 64'(mac_accumulate_internal), 64'd0);
            repeat (2) @(negedge clk);
            arst_n_in = 1'b1;
            repeat (8) @(negedge clk);
            check("abort_no_done", 64'(done_cnt), 64'(d0));
            check("abort_idle", 64'(busy), 64'd0);
        end else begin
            for (int w = 0; w < 3000 && done_cnt == d0; w++) @(negedge clk);
            check("done_pulse", 64'(done_cnt), 64'(d0 + 1));
            #3;
            check("idle_after_done", 64'(busy), 64'd0);
            check("results_left", 64'(exp_q.size()), 64'd0);
            if (check_lat) check("latency", 64'(rise_cyc - last_acc_cyc), 64'd5);
            if (qa.size() == 0) check("zero_no_mac", 64'(miv_cnt), 64'(m0));
        end
    endtask

    initial begin
        arst_n_in   = 1'b0;
        start       = 1'b0;
        num_groups  = '0;
        num_outputs = '0;
        use_bias    = 1'b0;
        bias_in     = '0;
        op_valid    = 1'b0;
        op_a        = '0;
        op_b        = '0;
        res_ready   = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_miv", 64'(mac_input_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        arst_n_in = 1'b1;
        repeat (2) @(negedge clk);

        rr_mode = 0;
        run_job(2, 1, 1'b0, 32'd0, 1, 0, 1'b1, 1'b0);
        run_job(2, 1, 1'b1, 32'd100, 1, 0, 1'b1, 1'b0);

        run_job(1, 3, 1'b0, 32'd0, 2, 0, 1'b0, 1'b0);
        check("consec_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("consec_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
            check("consec_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd1);
        end

        stall_seen = 0;
        rr_mode    = 2;
        fork
            run_job(1, 6, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);
            begin
                repeat (20) @(negedge clk);
                rr_mode = 0;
            end
        join
        check("stall_seen", 64'(stall_seen > 0), 64'd1);
        check("stall_handshakes", 64'(hs_cyc.size()), 64'd6);

        run_job(3, 2, 1'b1, 32'h0001_2345, 3, 0, 1'b0, 1'b0);
        run_job(3, 2, 1'b1, 32'h0001_2345, 3, 45, 1'b0, 1'b0);

        run_job(2, 1, 1'b0, 32'd0, 0, 0, 1'b0, 1'b1);
        run_job(2, 2, 1'b1, 32'd7, 0, 0, 1'b0, 1'b0);

        run_job(3, 0, 1'b0, 32'd0, 0, 0, 1'b0, 1'b0);

        rr_mode = 1;
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), 1'($urandom_range(1)),
                    $urandom(), 0, int'($urandom_range(50)), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
